// File: rtl/k12a_mem_if.sv
// k12a_mem_if: bridges the k12a shared address/data buses to an asynchronous 8-bit SRAM
// Ports: clock, reset_n (async, active-low); mem_req/mem_we start a read or write, mem_load_n
// puts the read-data register on data_bus; addr_bus/data_bus are the shared buses; mem_busy and
// mem_done report progress; sram_addr/sram_data/sram_ce_n/sram_oe_n/sram_we_n drive the SRAM.
`timescale 1ns/1ps
module k12a_mem_if #(
  parameter int WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic        mem_load_n,
  inout  wire  [15:0] addr_bus,
  inout  wire  [7:0]  data_bus,
  output logic        mem_busy,
  output logic        mem_done,
  output logic [15:0] sram_addr,
  inout  wire  [7:0]  sram_data,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);
  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_e;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d, rdata_q, rdata_d;
  logic        last_wait, drive;
  assign last_wait = cnt_q == WAIT_LAST;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  // the wait counter is shared by RD and WR_PULSE and is back at zero whenever either exits
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (mem_req) begin
        addr_d  = addr_bus;
        wdata_d = mem_we ? data_bus : wdata_q;
        state_d = mem_we ? WR_SETUP : RD;
      end
      RD: begin
        cnt_d   = last_wait ? 4'd0 : cnt_q + 4'd1;
        rdata_d = last_wait ? sram_data : rdata_q;
        state_d = last_wait ? DONE : RD;
      end
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: begin
        cnt_d   = last_wait ? 4'd0 : cnt_q + 4'd1;
        state_d = last_wait ? WR_HOLD : WR_PULSE;
      end
      WR_HOLD: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    drive     = state_q == WR_SETUP || state_q == WR_PULSE || state_q == WR_HOLD;
    mem_busy  = state_q != IDLE;
    mem_done  = state_q == DONE;
    sram_ce_n = !(drive || state_q == RD);
    sram_oe_n = state_q != RD;
    sram_we_n = state_q != WR_PULSE;
  end
  assign sram_addr = addr_q;
  assign sram_data = drive ? wdata_q : 8'bz;
  assign data_bus  = mem_load_n ? 8'bz : rdata_q;
endmodule

// File: doc/k12a_mem_if.md
K12A_MEM_IF -- requirements
Module: k12a_mem_if

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, extra SRAM access cycles per transfer, legal range 0..15.
REQ-002 SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port mem_req  input  1  start a transfer; sampled only in IDLE.
REQ-005 SHALL have port mem_we  input  1  transfer direction, sampled with mem_req; 1 = write, 0 = read.
REQ-006 SHALL have port mem_load_n  input  1  active-low; drive read-data register onto data_bus.
REQ-007 SHALL have port addr_bus  inout  16  shared address bus; this block only samples it and never drives it.
REQ-008 SHALL have port data_bus  inout  8  shared data bus; sampled for writes, driven for mem_load_n = 0.
REQ-009 SHALL have port mem_busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port mem_done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port sram_addr  output  16  external SRAM address.
REQ-012 SHALL have port sram_data  inout  8  external SRAM data.
REQ-013 SHALL have ports sram_ce_n, sram_oe_n, sram_we_n  output  1 each  active-low SRAM strobes.

Function
REQ-014 SHALL implement states IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE, with a 4-bit wait counter.
REQ-015 In IDLE with mem_req = 1 at edge N, SHALL latch addr_bus into addr_reg; if mem_we = 1, SHALL also latch data_bus into wdata_reg; next state is RD if mem_we = 0, else WR_SETUP.
REQ-016 sram_addr SHALL equal addr_reg at all times.
REQ-017 RD SHALL last WAIT_STATES+1 cycles with ce_n = 0, oe_n = 0, we_n = 1.
REQ-018 On the edge leaving RD, SHALL latch sram_data into rdata_reg and enter DONE.
REQ-019 WR_SETUP SHALL last 1 cycle with ce_n = 0, oe_n = 1, we_n = 1, and sram_data driven with wdata_reg.
REQ-020 WR_PULSE SHALL follow WR_SETUP, lasting WAIT_STATES+1 cycles with we_n = 0, ce_n = 0, and sram_data still driven.
REQ-021 WR_HOLD SHALL follow WR_PULSE, lasting 1 cycle with we_n = 1, ce_n = 0, and sram_data still driven; next state is DONE.
REQ-022 DONE SHALL last 1 cycle with mem_done = 1 and all strobes high, then return to IDLE.
REQ-023 Cycle timing for mem_req at edge N:
- read: DONE entered at edge N+WAIT_STATES+1; IDLE at N+WAIT_STATES+2.
- write: DONE entered at edge N+WAIT_STATES+3; IDLE at N+WAIT_STATES+4.
REQ-024 sram_data SHALL be high-Z outside WR_SETUP, WR_PULSE and WR_HOLD.
REQ-025 oe_n and we_n SHALL never both be low.
REQ-026 mem_req outside IDLE SHALL be ignored; no queuing.
REQ-027 data_bus SHALL be driven with rdata_reg whenever mem_load_n = 0, in any state; otherwise high-Z.
REQ-028 rdata_reg SHALL hold its value until the next read completes.
REQ-029 mem_load_n = 0 in the same cycle as an accepted write (mem_req = 1, mem_we = 1) SHALL be illegal and flagged by a bench assertion; RTL behaviour in that case is unspecified.
REQ-030 WAIT_STATES = 0 SHALL give a 1-cycle RD and a 1-cycle WR_PULSE.

Reset
REQ-031 reset_n = 0 SHALL immediately, without waiting for a clock edge:
- force state IDLE;
- clear addr_reg, wdata_reg and rdata_reg to 0 and the wait counter to 0;
- force mem_busy = 0, mem_done = 0;
- force sram_ce_n = sram_oe_n = sram_we_n = 1;
- release sram_data.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer with no mem_done pulse; rdata_reg reads 0 afterwards.

Verification
REQ-033 Read, WAIT_STATES = 1: SRAM[0x1234] = 0x5A, mem_req/mem_we = 1/0 with addr_bus = 0x1234 at edge N -> oe_n low 2 cycles, mem_done high in the cycle after edge N+2, then mem_load_n = 0 -> data_bus = 0x5A.
REQ-034 Write, WAIT_STATES = 1: addr_bus = 0xBEEF, data_bus = 0xC3, mem_we = 1 -> sequence SETUP(1), PULSE(2, we_n = 0), HOLD(1); SRAM[0xBEEF] = 0xC3; mem_done after edge N+4; sram_data high-Z afterwards.
REQ-035 WAIT_STATES = 0, back-to-back: read issued the cycle IDLE is re-entered -> accepted; mem_req held during the busy cycles -> no extra transfer.
REQ-036 Reset pulse during WR_PULSE -> strobes high and sram_data high-Z before the next edge; no mem_done; next read proceeds normally.
REQ-037 Boundary addresses 0x0000 and 0xFFFF plus rdata hold: read 0xFFFF = 0x81, then a write to 0x0000, then mem_load_n = 0 -> data_bus = 0x81.
